pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, program-counter and return-address width.
REQ-002 SHALL have parameter OFF_W, default 8, relative-branch offset width (OFF_W <= ADDR_W).
REQ-003 SHALL have parameter DEPTH, default 8, return-stack entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
REQ-006 SHALL have port stall  input  1  freeze all state this cycle.
REQ-007 SHALL have port pc_src  input  2  next-PC select: 00 sequential, 01 absolute, 10 return, 11 relative.
REQ-008 SHALL have port target  input  ADDR_W  absolute jump address.
REQ-009 SHALL have port offset  input  OFF_W  signed two's-complement branch offset.
REQ-010 SHALL have port push  input  1  call: save pc+1 on return stack.
REQ-011 SHALL have port pop  input  1  return: remove top entry.
REQ-012 SHALL have port clear_err  input  1  synchronous clear of sticky error flags.
REQ-013 SHALL have port pc  output  ADDR_W  current PC (registered).
REQ-014 SHALL have port ret_addr  output  ADDR_W  top-of-stack entry, combinational; 0 when empty.
REQ-015 SHALL have port depth  output  $clog2(DEPTH+1)  valid entries, 0..DEPTH.
REQ-016 SHALL have ports full, empty  output  1 each  depth==DEPTH, depth==0.
REQ-017 SHALL have ports stack_overflow, stack_underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL, when stall=0, load next pc per pc_src: 00 pc+1; 01 target; 10 ret_addr; 11 pc+1+sign_extend(offset).
REQ-019 SHALL compute all PC arithmetic modulo 2^ADDR_W (pc=all-ones, pc_src=00 -> pc=0).
REQ-020 SHALL, when stall=1, hold pc, stack contents, depth and flags; push, pop and clear_err are ignored.
REQ-021 SHALL, on push alone with not full, write pc+1 (value before the update) to slot depth and increment depth; latency 1 cycle to ret_addr.
REQ-022 SHALL, on pop alone with not empty, decrement depth; ret_addr shows the new top in the following cycle.
REQ-023 SHALL, on push and pop together with not empty, overwrite the top entry with pc+1, depth unchanged; with empty, behave as push alone.
REQ-024 SHALL, on push alone while full, drop the write, leave depth at DEPTH and set stack_overflow.
REQ-025 SHALL, on pop alone while empty, leave depth at 0 and set stack_underflow.
REQ-026 SHALL, on pc_src=10 while empty, load pc+1 instead of ret_addr and set stack_underflow.
REQ-027 SHALL treat push/pop independently of pc_src; pc_src=10 does not by itself pop.
REQ-028 SHALL clear both sticky flags on clear_err=1 unless the same cycle raises a new error (set wins).
REQ-029 SHALL derive full/empty from depth only, never from pointer comparison.

Reset
REQ-030 SHALL, while rst=0, force pc=0, depth=0, empty=1, full=0, ret_addr=0, stack_overflow=0, stack_underflow=0.
REQ-031 SHALL abandon any in-progress push/pop when rst asserts mid-cycle; stack contents are not required to be cleared.
REQ-032 SHALL resume normal operation at the first rising edge after rst returns to 1.

Verification
REQ-033 SHALL cover sequential and wrap: ADDR_W=12, reset then 4096 cycles pc_src=00 -> pc counts 0..4095 then 0.
REQ-034 SHALL cover relative branch: pc=0x010, offset=0x80 (-128), pc_src=11 -> pc=0xF91; offset=0x05 -> pc=0x016.
REQ-035 SHALL cover call/return: pc=0x100, push=1, pc_src=01, target=0x200 -> pc=0x200, ret_addr=0x101, depth=1; next cycle pop=1, pc_src=10 -> pc=0x101, depth=0, empty=1.
REQ-036 SHALL cover overflow: 9 pushes with DEPTH=8 -> depth=8, full=1, stack_overflow=1, ret_addr equals 8th saved address; clear_err=1 -> flag 0.
REQ-037 SHALL cover underflow: reset, pop=1, pc_src=10 at pc=0x005 -> pc=0x006, depth=0, stack_underflow=1.
REQ-038 SHALL cover stall and async reset: stall=1 with push=1, pc_src=01 -> pc, depth unchanged; rst=0 between edges -> pc=0, depth=0 before next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return stack.
// Sequential, absolute, relative and return targets; sticky stack errors.
module pc_sequencer #(
   parameter int ADDR_W = 12,
   parameter int OFF_W  = 8,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic [1:0]                   pc_src,
   input  logic [ADDR_W-1:0]            target,
   input  logic [OFF_W-1:0]             offset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear_err,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            ret_addr,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty,
   output logic                         stack_overflow,
   output logic                         stack_underflow
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] SRC_SEQ = 2'b00;
   localparam logic [1:0] SRC_ABS = 2'b01;
   localparam logic [1:0] SRC_RET = 2'b10;
   localparam logic [1:0] SRC_REL = 2'b11;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] pc_nxt;
   logic [AW-1:0]     top_idx;
   logic [AW-1:0]     wr_idx;
   logic              do_new;
   logic              do_ovr;
   logic              do_dec;
   logic              ovf_set;
   logic              unf_set;

   assign full     = (depth == DW'(DEPTH));
   assign empty    = (depth == '0);
   assign top_idx  = AW'(depth - DW'(1));
   assign ret_addr = empty ? '0 : mem[top_idx];
   assign pc_inc   = pc + ADDR_W'(1);
   assign off_ext  = ADDR_W'($signed(offset));

   // push+pop on an empty stack degrades to a plain push
   assign do_ovr  = push && pop && !empty;
   assign do_new  = push && (!pop || empty) && !full;
   assign do_dec  = pop && !push && !empty;
   assign ovf_set = push && !pop && full;
   assign unf_set = (pop && !push && empty) ||
                    (pc_src == SRC_RET && empty);
   assign wr_idx  = do_ovr ? top_idx : AW'(depth);

   always_comb begin
      pc_nxt = pc_inc;
      case (pc_src)
         SRC_SEQ: pc_nxt = pc_inc;
         SRC_ABS: pc_nxt = target;
         SRC_RET: pc_nxt = empty ? pc_inc : ret_addr;
         SRC_REL: pc_nxt = pc_inc + off_ext;
         default: pc_nxt = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc              <= '0;
         depth           <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else if (!stall) begin
         pc <= pc_nxt;
         if (do_new)
            depth <= depth + DW'(1);
         else if (do_dec)
            depth <= depth - DW'(1);
         stack_overflow  <= (stack_overflow && !clear_err) || ovf_set;
         stack_underflow <= (stack_underflow && !clear_err) || unf_set;
      end
   end

   // Slot contents need no reset: depth alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!stall && (do_new || do_ovr))
         mem[wr_idx] <= pc_inc;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Vector table plus hand-written overflow, underflow and reset sequences.
module tb_pc_sequencer;

   typedef struct {
      logic        st;
      logic [1:0]  src;
      logic [11:0] tgt;
      logic [7:0]  off;
      logic        ps;
      logic        pp;
      logic        cl;
      logic [11:0] e_pc;
      logic [3:0]  e_dep;
      logic [11:0] e_ret;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   typedef struct {
      logic [11:0] pc;
      logic [3:0]  dep;
      logic [11:0] ret;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  pc_src = 2'b00;
   logic [11:0] target = '0;
   logic [7:0]  offset = '0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic        clear_err = 1'b0;
   logic [11:0] pc;
   logic [11:0] ret_addr;
   logic [3:0]  depth;
   logic        full;
   logic        empty;
   logic        stack_overflow;
   logic        stack_underflow;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t tbl[18];

   pc_sequencer #(.ADDR_W(12), .OFF_W(8), .DEPTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .pc_src(pc_src),
      .target(target),
      .offset(offset),
      .push(push),
      .pop(pop),
      .clear_err(clear_err),
      .pc(pc),
      .ret_addr(ret_addr),
      .depth(depth),
      .full(full),
      .empty(empty),
      .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input logic st, input logic [1:0] s,
      input logic [11:0] t, input logic [7:0] o,
      input logic ps, input logic pp, input logic cl,
      input logic [11:0] ep, input logic [3:0] ed,
      input logic [11:0] er, input logic eo, input logic eu);
      vec_t v;
      v.st = st; v.src = s; v.tgt = t; v.off = o;
      v.ps = ps; v.pp = pp; v.cl = cl;
      v.e_pc = ep; v.e_dep = ed; v.e_ret = er;
      v.e_ovf = eo; v.e_unf = eu;
      return v;
   endfunction

   task automatic chk(input string nm, input int tag,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d] act=%0h req=%0h", nm, tag, act, req);
      end
   endtask

   task automatic check_out(input int tag);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard[%0d] act=empty req=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      chk("pc", tag, 32'(pc), 32'(e.pc));
      chk("depth", tag, 32'(depth), 32'(e.dep));
      chk("ret_addr", tag, 32'(ret_addr), 32'(e.ret));
      chk("full", tag, 32'(full), 32'(e.dep == 4'd8));
      chk("empty", tag, 32'(empty), 32'(e.dep == 4'd0));
      chk("ovf", tag, 32'(stack_overflow), 32'(e.ovf));
      chk("unf", tag, 32'(stack_underflow), 32'(e.unf));
   endtask

   task automatic step(input vec_t v, input int tag);
      exp_t e;
      stall = v.st; pc_src = v.src; target = v.tgt;
      offset = v.off; push = v.ps; pop = v.pp;
      clear_err = v.cl;
      e.pc = v.e_pc; e.dep = v.e_dep; e.ret = v.e_ret;
      e.ovf = v.e_ovf; e.unf = v.e_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic idle_inputs();
      stall = 0; pc_src = 0; target = 0; offset = 0;
      push = 0; pop = 0; clear_err = 0;
   endtask

   task automatic do_reset(input int tag);
      exp_t z;
      idle_inputs();
      #2;
      rst = 1'b0;
      #1;
      z.pc = 0; z.dep = 0; z.ret = 0; z.ovf = 0; z.unf = 0;
      exp_q.push_back(z);
      check_out(tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      exp_t z;
      z.pc = 0; z.dep = 0; z.ret = 0; z.ovf = 0; z.unf = 0;

      tbl[0]  = mk(0, 2'b01, 12'h010, 8'h00, 0, 0, 0, 12'h010, 0, 12'h000, 0, 0);
      tbl[1]  = mk(0, 2'b11, 12'h000, 8'h80, 0, 0, 0, 12'hF91, 0, 12'h000, 0, 0);
      tbl[2]  = mk(0, 2'b01, 12'h010, 8'h00, 0, 0, 0, 12'h010, 0, 12'h000, 0, 0);
      tbl[3]  = mk(0, 2'b11, 12'h000, 8'h05, 0, 0, 0, 12'h016, 0, 12'h000, 0, 0);
      tbl[4]  = mk(0, 2'b01, 12'h100, 8'h00, 0, 0, 0, 12'h100, 0, 12'h000, 0, 0);
      tbl[5]  = mk(0, 2'b01, 12'h200, 8'h00, 1, 0, 0, 12'h200, 1, 12'h101, 0, 0);
      tbl[6]  = mk(0, 2'b10, 12'h000, 8'h00, 0, 1, 0, 12'h101, 0, 12'h000, 0, 0);
      tbl[7]  = mk(0, 2'b10, 12'h000, 8'h00, 0, 0, 0, 12'h102, 0, 12'h000, 0, 1);
      tbl[8]  = mk(0, 2'b00, 12'h000, 8'h00, 0, 0, 1, 12'h103, 0, 12'h000, 0, 0);
      tbl[9]  = mk(0, 2'b00, 12'h000, 8'h00, 0, 1, 1, 12'h104, 0, 12'h000, 0, 1);
      tbl[10] = mk(0, 2'b00, 12'h000, 8'h00, 0, 0, 1, 12'h105, 0, 12'h000, 0, 0);
      tbl[11] = mk(0, 2'b00, 12'h000, 8'h00, 1, 0, 0, 12'h106, 1, 12'h106, 0, 0);
      tbl[12] = mk(0, 2'b10, 12'h000, 8'h00, 0, 0, 0, 12'h106, 1, 12'h106, 0, 0);
      tbl[13] = mk(0, 2'b00, 12'h000, 8'h00, 1, 1, 0, 12'h107, 1, 12'h107, 0, 0);
      tbl[14] = mk(1, 2'b01, 12'h3FF, 8'h00, 1, 0, 1, 12'h107, 1, 12'h107, 0, 0);
      tbl[15] = mk(0, 2'b00, 12'h000, 8'h00, 0, 1, 0, 12'h108, 0, 12'h000, 0, 0);
      tbl[16] = mk(0, 2'b00, 12'h000, 8'h00, 1, 1, 0, 12'h109, 1, 12'h109, 0, 0);
      tbl[17] = mk(0, 2'b00, 12'h000, 8'h00, 0, 1, 0, 12'h10A, 0, 12'h000, 0, 0);

      // sequential count through the full 12-bit range and wrap
      do_reset(1000);
      for (int k = 1; k <= 4096; k++)
         step(mk(0, 2'b00, 0, 0, 0, 0, 0, 12'(k), 0, 0, 0, 0), k);

      do_reset(2000);
      for (int i = 0; i < 18; i++)
         step(tbl[i], 2100 + i);

      // fill, overflow, clear, then replace-top while full
      do_reset(3000);
      for (int i = 0; i < 8; i++)
         step(mk(0, 2'b00, 0, 0, 1, 0, 0, 12'(i + 1), 4'(i + 1),
                 12'(i + 1), 0, 0), 3100 + i);
      step(mk(0, 2'b00, 0, 0, 1, 0, 0, 12'd9, 8, 12'd8, 1, 0), 3108);
      step(mk(0, 2'b00, 0, 0, 0, 0, 1, 12'd10, 8, 12'd8, 0, 0), 3109);
      step(mk(0, 2'b00, 0, 0, 1, 1, 0, 12'd11, 8, 12'd11, 0, 0), 3110);

      // async reset between edges with a push pending
      push = 1'b1;
      pc_src = 2'b01;
      target = 12'h3AB;
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(z);
      check_out(3200);
      @(posedge clk);
      #1;
      exp_q.push_back(z);
      check_out(3201);
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      step(mk(0, 2'b00, 0, 0, 0, 0, 0, 12'd1, 0, 0, 0, 0), 3202);

      // return on empty stack
      do_reset(4000);
      step(mk(0, 2'b01, 12'h005, 0, 0, 0, 0, 12'h005, 0, 0, 0, 0), 4001);
      step(mk(0, 2'b10, 0, 0, 0, 1, 0, 12'h006, 0, 0, 0, 1), 4002);
      step(mk(1, 2'b00, 0, 0, 1, 0, 1, 12'h006, 0, 0, 0, 1), 4003);

      chk("sb_drain", 9000, 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
